text_entry_buffer: RTL and testbench
====================================

Name: text_entry_buffer

Overview:
Parametrised keyboard line-entry buffer that holds DEPTH characters and a cursor, and accepts edit keys from the keyboard decoder.
- Supports cursor left/right, backspace, character write and enter.
- On enter, streams the committed line out one character per handshake, then clears for the next entry.
- Sits between the ASCII key decoder and the display/compare logic.

Parameters:
DEPTH, 10, number of character slots (2..64)
CHAR_W, 8, bits per character
FILL_CHAR, 8'h20, value of an empty slot
PTR_W, $clog2(DEPTH+1), width of cursor/length

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
load  input  1  edit enable; keys ignored when 0
char_valid  input  1  one-cycle strobe: char_code is a new key
char_code  input  CHAR_W  key code
letters  output  DEPTH*CHAR_W  buffer contents, slot 0 in bits [CHAR_W-1:0]
cursor  output  PTR_W  current edit slot
length  output  PTR_W  number of written slots
done_load  output  1  one-cycle pulse: key consumed
enter_pressed  output  1  one-cycle pulse: enter accepted
busy  output  1  1 while in STREAM state
out_char  output  CHAR_W  streamed character
out_valid  output  1  out_char valid
out_last  output  1  out_char is the final character of the line
out_ready  input  1  downstream accepts out_char

Behaviour:
Reset (async, resetn=0):
- All slots = FILL_CHAR; cursor=0; length=0.
- done_load, enter_pressed, busy, out_valid, out_last = 0.
- State = EDIT.

States: EDIT, STREAM.

EDIT, key accepted when load=1 and char_valid=1. One key per cycle. Outputs register on the same clock edge; done_load pulses 1 cycle after the accepting edge.
- 8'h12 LEFT: cursor -= 1 if cursor>0, else hold.
- 8'h14 RIGHT: cursor += 1 if cursor < length and cursor < DEPTH-1, else hold.
- 8'h08 BACKSPACE: if cursor>0, slot[cursor-1] = FILL_CHAR and cursor -= 1. If the old cursor equalled length, length -= 1. cursor=0 means no change, but done_load still pulses.
- 8'h0A ENTER:
  - enter_pressed pulses.
  - If length>0, go to STREAM.
  - If length=0, stay in EDIT (no stream).
- Any other code: slot[cursor] = char_code; length = max(length, cursor+1); cursor += 1 if cursor < DEPTH-1.
  - At cursor=DEPTH-1, repeated writes overwrite the last slot.
- Every accepted key produces exactly one done_load pulse.
- Keys with load=0 or char_valid=0 produce no effect and no pulse.

STREAM:
- busy=1. out_valid=1 starting the cycle after entry.
- out_char = slot[idx], where idx runs from 0 to length-1. out_last=1 when idx=length-1.
- idx advances only on out_valid and out_ready. out_char is held stable while out_ready=0.
- After the last transfer:
  - out_valid=0, busy=0.
  - All slots = FILL_CHAR; cursor=0; length=0.
  - Return to EDIT on the next cycle.
- char_valid in STREAM is ignored: no done_load and no buffer change.
- load=0 does not abort the stream.

Reset mid-STREAM aborts immediately to the reset state.

Optional Feature:
Macro: TEXT_ENTRY_INSERT_EN.
Defined (insert mode):
- Write: slots cursor..DEPTH-2 shift right by one (old slot DEPTH-1 dropped), slot[cursor] = char_code, length = min(length+1, DEPTH), cursor advances as in overwrite mode.
- Backspace (cursor>0): slots cursor..DEPTH-1 shift left into cursor-1..DEPTH-2, slot[DEPTH-1] = FILL_CHAR, length -= 1, cursor -= 1.
Undefined: overwrite behaviour exactly as in Behaviour. No extra logic is synthesised.

Test Plan:
- Reset then type 'A','B','C' (8'h41,42,43) with load=1 → slots 0..2 = 41,42,43; cursor=3; length=3; three done_load pulses, each one cycle after its strobe.
- From 'ABC': LEFT ×4 → cursor stops at 0; RIGHT ×5 → cursor stops at 3; all 9 keys pulse done_load.
- From 'ABC', cursor=3: BACKSPACE → slot2=8'h20, cursor=2, length=2. Then with cursor=0, BACKSPACE → no change, done_load pulses.
- DEPTH=10: type 12 chars '0'..'9','X','Y' → slot9=8'h59 ('Y'), cursor=9, length=10.
- From 'ABC', ENTER with out_ready held low for 3 cycles then high → enter_pressed pulses; busy=1; out_char stays 8'h41 while stalled; then 41,42,43 with out_last on 43; buffer cleared; EDIT resumes. A char_valid strobe during STREAM is ignored.
- With TEXT_ENTRY_INSERT_EN: 'AC', LEFT, 'B' → slots 41,42,43, length=3, cursor=2. Then BACKSPACE → slots 41,43,20, length=2, cursor=1. Assert resetn=0 mid-stream → outputs return to reset values asynchronously.

Source files
------------

// File: rtl/text_entry_buffer.sv
// text_entry_buffer
//
// Keyboard line-entry buffer. Holds DEPTH character slots plus an edit cursor
// and accepts edit keys from the ASCII key decoder. ENTER commits the line:
// the buffer streams it out one character per valid/ready handshake, then
// clears itself and returns to editing.
//
// Build option:
//   TEXT_ENTRY_INSERT_EN  - when defined, writes insert at the cursor (tail
//                           shifts right) and backspace closes the gap (tail
//                           shifts left). When undefined, writes overwrite the
//                           slot at the cursor and backspace blanks one slot.
//
// Ports:
//   clk           system clock
//   resetn        asynchronous active-low reset
//   load          edit enable; keys are ignored while low
//   char_valid    one-cycle strobe marking char_code as a new key
//   char_code     key code (0x12 LEFT, 0x14 RIGHT, 0x08 BACKSPACE, 0x0A ENTER,
//                 anything else is a character)
//   letters       buffer contents, slot 0 in bits [CHAR_W-1:0]
//   cursor        current edit slot
//   length        number of written slots
//   done_load     one-cycle pulse: a key was consumed
//   enter_pressed one-cycle pulse: ENTER was consumed
//   busy          high while the committed line is being streamed
//   out_char      streamed character
//   out_valid     out_char is valid
//   out_last      out_char is the final character of the line
//   out_ready     downstream accepts out_char

module text_entry_buffer #(
    parameter int                DEPTH     = 10,
    parameter int                CHAR_W    = 8,
    parameter logic [CHAR_W-1:0] FILL_CHAR = CHAR_W'(8'h20),
    parameter int                PTR_W     = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    load,
    input  logic                    char_valid,
    input  logic [CHAR_W-1:0]       char_code,
    output logic [DEPTH*CHAR_W-1:0] letters,
    output logic [PTR_W-1:0]        cursor,
    output logic [PTR_W-1:0]        length,
    output logic                    done_load,
    output logic                    enter_pressed,
    output logic                    busy,
    output logic [CHAR_W-1:0]       out_char,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready
);

    localparam logic [CHAR_W-1:0] KEY_LEFT  = CHAR_W'(8'h12);
    localparam logic [CHAR_W-1:0] KEY_RIGHT = CHAR_W'(8'h14);
    localparam logic [CHAR_W-1:0] KEY_BKSP  = CHAR_W'(8'h08);
    localparam logic [CHAR_W-1:0] KEY_ENTER = CHAR_W'(8'h0A);

    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] FULL_LEN  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE       = PTR_W'(1);

    typedef enum logic {
        S_EDIT   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CHAR_W-1:0] slots_q [DEPTH];
    logic [CHAR_W-1:0] slots_d [DEPTH];
    logic [PTR_W-1:0]  cursor_q, cursor_d;
    logic [PTR_W-1:0]  length_q, length_d;
    logic [PTR_W-1:0]  idx_q, idx_d;
    logic              done_load_q, done_load_d;
    logic              enter_pressed_q, enter_pressed_d;
    logic              busy_q, busy_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    wire key_accept = load && char_valid;

    always_comb begin
        state_d         = state_q;
        cursor_d        = cursor_q;
        length_d        = length_q;
        idx_d           = idx_q;
        done_load_d     = 1'b0;
        enter_pressed_d = 1'b0;
        busy_d          = busy_q;
        out_valid_d     = out_valid_q;
        out_last_d      = out_last_q;
        for (int i = 0; i < DEPTH; i++) begin
            slots_d[i] = slots_q[i];
        end

        case (state_q)
            S_EDIT: begin
                if (key_accept) begin
                    done_load_d = 1'b1;
                    case (char_code)
                        KEY_LEFT: begin
                            if (cursor_q != '0) begin
                                cursor_d = cursor_q - ONE;
                            end
                        end

                        KEY_RIGHT: begin
                            if ((cursor_q < length_q) && (cursor_q < LAST_SLOT)) begin
                                cursor_d = cursor_q + ONE;
                            end
                        end

                        KEY_BKSP: begin
                            // At cursor 0 the key is still consumed (done_load) but edits nothing.
                            if (cursor_q != '0) begin
                                cursor_d = cursor_q - ONE;
`ifdef TEXT_ENTRY_INSERT_EN
                                // Close the gap: everything from the cursor moves one slot left.
                                for (int i = 0; i < DEPTH - 1; i++) begin
                                    if (PTR_W'(i) >= cursor_q - ONE) begin
                                        slots_d[i] = slots_q[i + 1];
                                    end
                                end
                                slots_d[DEPTH - 1] = FILL_CHAR;
                                length_d           = length_q - ONE;
`else
                                for (int i = 0; i < DEPTH; i++) begin
                                    if (PTR_W'(i) == cursor_q - ONE) begin
                                        slots_d[i] = FILL_CHAR;
                                    end
                                end
                                // Only erasing the tail character shortens the line.
                                if (cursor_q == length_q) begin
                                    length_d = length_q - ONE;
                                end
`endif
                            end
                        end

                        KEY_ENTER: begin
                            enter_pressed_d = 1'b1;
                            // An empty line is acknowledged but never streamed.
                            if (length_q != '0) begin
                                state_d = S_STREAM;
                                busy_d  = 1'b1;
                                idx_d   = '0;
                            end
                        end

                        default: begin
`ifdef TEXT_ENTRY_INSERT_EN
                            // Open a hole at the cursor; the old last slot falls off the end.
                            for (int i = 1; i < DEPTH; i++) begin
                                if (PTR_W'(i) > cursor_q) begin
                                    slots_d[i] = slots_q[i - 1];
                                end
                            end
                            if (length_q != FULL_LEN) begin
                                length_d = length_q + ONE;
                            end
`else
                            // Cursor never exceeds length, so only a write at the tail grows it.
                            if (cursor_q == length_q) begin
                                length_d = cursor_q + ONE;
                            end
`endif
                            for (int i = 0; i < DEPTH; i++) begin
                                if (PTR_W'(i) == cursor_q) begin
                                    slots_d[i] = char_code;
                                end
                            end
                            // The cursor parks on the last slot; further writes land there.
                            if (cursor_q != LAST_SLOT) begin
                                cursor_d = cursor_q + ONE;
                            end
                        end
                    endcase
                end
            end

            S_STREAM: begin
                // Keys are ignored here; load going low does not abort the stream.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_last_d  = (idx_q == length_q - ONE);
                end else if (out_ready) begin
                    if (out_last_q) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            slots_d[i] = FILL_CHAR;
                        end
                        cursor_d    = '0;
                        length_d    = '0;
                        idx_d       = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        busy_d      = 1'b0;
                        state_d     = S_EDIT;
                    end else begin
                        idx_d      = idx_q + ONE;
                        // Look ahead: the next index is last when idx+2 reaches length.
                        out_last_d = (idx_q + PTR_W'(2) == length_q);
                    end
                end
            end

            default: begin
                state_d = S_EDIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= S_EDIT;
            cursor_q        <= '0;
            length_q        <= '0;
            idx_q           <= '0;
            done_load_q     <= 1'b0;
            enter_pressed_q <= 1'b0;
            busy_q          <= 1'b0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= FILL_CHAR;
            end
        end else begin
            state_q         <= state_d;
            cursor_q        <= cursor_d;
            length_q        <= length_d;
            idx_q           <= idx_d;
            done_load_q     <= done_load_d;
            enter_pressed_q <= enter_pressed_d;
            busy_q          <= busy_d;
            out_valid_q     <= out_valid_d;
            out_last_q      <= out_last_d;
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end

    // Read-out mux written as a compare loop so the index width need not match the array size.
    always_comb begin
        out_char = FILL_CHAR;
        for (int i = 0; i < DEPTH; i++) begin
            if (PTR_W'(i) == idx_q) begin
                out_char = slots_q[i];
            end
        end
    end

    always_comb begin
        letters = '0;
        for (int i = 0; i < DEPTH; i++) begin
            letters[i*CHAR_W +: CHAR_W] = slots_q[i];
        end
    end

    assign cursor        = cursor_q;
    assign length        = length_q;
    assign done_load     = done_load_q;
    assign enter_pressed = enter_pressed_q;
    assign busy          = busy_q;
    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;

endmodule

// File: tb/tb_text_entry_buffer.sv
// Testbench for text_entry_buffer: directed edits, line streaming with stalls,
// randomized key traffic against a reference model, and reset mid-stream.
`timescale 1ns/1ps
module tb_text_entry_buffer;

    localparam int DEPTH  = 10;
    localparam int CHAR_W = 8;
    localparam int PTR_W  = $clog2(DEPTH + 1);
    localparam logic [7:0] FILL    = 8'h20;
    localparam logic [7:0] K_LEFT  = 8'h12;
    localparam logic [7:0] K_RIGHT = 8'h14;
    localparam logic [7:0] K_BS    = 8'h08;
    localparam logic [7:0] K_ENTER = 8'h0A;

    logic                    clk = 1'b0;
    logic                    resetn = 1'b0;
    logic                    load = 1'b0;
    logic                    char_valid = 1'b0;
    logic [CHAR_W-1:0]       char_code = '0;
    logic                    out_ready = 1'b0;
    logic [DEPTH*CHAR_W-1:0] letters;
    logic [PTR_W-1:0]        cursor;
    logic [PTR_W-1:0]        length;
    logic                    done_load;
    logic                    enter_pressed;
    logic                    busy;
    logic [CHAR_W-1:0]       out_char;
    logic                    out_valid;
    logic                    out_last;

    text_entry_buffer #(.DEPTH(DEPTH), .CHAR_W(CHAR_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .load         (load),
        .char_valid   (char_valid),
        .char_code    (char_code),
        .letters      (letters),
        .cursor       (cursor),
        .length       (length),
        .done_load    (done_load),
        .enter_pressed(enter_pressed),
        .busy         (busy),
        .out_char     (out_char),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the line as an array of characters plus cursor and length.
    logic [7:0] m_slot [DEPTH];
    int         m_cur;
    int         m_len;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) m_slot[i] = FILL;
        m_cur = 0;
        m_len = 0;
    endfunction

    function automatic logic [DEPTH*CHAR_W-1:0] model_letters();
        logic [DEPTH*CHAR_W-1:0] v;
        v = '0;
        for (int i = 0; i < DEPTH; i++) v[i*CHAR_W +: CHAR_W] = m_slot[i];
        return v;
    endfunction

    function automatic void model_key(input logic [7:0] c);
        if (c == K_LEFT) begin
            if (m_cur > 0) m_cur--;
        end else if (c == K_RIGHT) begin
            if (m_cur < m_len && m_cur < DEPTH - 1) m_cur++;
        end else if (c == K_BS) begin
            if (m_cur > 0) begin
`ifdef TEXT_ENTRY_INSERT_EN
                // delete character at cur-1, tail closes up
                for (int j = m_cur - 1; j < DEPTH - 1; j++) m_slot[j] = m_slot[j + 1];
                m_slot[DEPTH - 1] = FILL;
                m_len--;
`else
                m_slot[m_cur - 1] = FILL;
                if (m_cur == m_len) m_len--;
`endif
                m_cur--;
            end
        end else begin
`ifdef TEXT_ENTRY_INSERT_EN
            for (int j = DEPTH - 1; j > m_cur; j--) m_slot[j] = m_slot[j - 1];
            m_slot[m_cur] = c;
            m_len = (m_len + 1 > DEPTH) ? DEPTH : m_len + 1;
`else
            m_slot[m_cur] = c;
            if (m_cur + 1 > m_len) m_len = m_cur + 1;
`endif
            if (m_cur < DEPTH - 1) m_cur++;
        end
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, "_letters"}, 128'(letters), 128'(model_letters()));
        check_eq({tag, "_cursor"}, 128'(cursor), 128'(m_cur));
        check_eq({tag, "_length"}, 128'(length), 128'(m_len));
    endtask

    task automatic press(input logic [7:0] code, input logic ld, input logic cv);
        @(negedge clk);
        load       = ld;
        char_valid = cv;
        char_code  = code;
        @(posedge clk);
        #1;
        if (ld && cv) model_key(code);
        check_eq("done_load", 128'(done_load), 128'(ld && cv));
        check_eq("enter_idle", 128'(enter_pressed), 128'(0));
        check_state("key");
        char_valid = 1'b0;
    endtask

    task automatic do_enter(input int nstall, input bit rnd_ready, input bit poke);
        logic [7:0] line [$];
        int  len;
        int  idx;
        int  stalls;
        int  cyc;
        bit  rdy;
        len = m_len;
        line = {};
        for (int i = 0; i < len; i++) line.push_back(m_slot[i]);
        @(negedge clk);
        load       = 1'b1;
        char_valid = 1'b1;
        char_code  = K_ENTER;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        check_eq("enter_pulse", 128'(enter_pressed), 128'(1));
        check_eq("enter_done_load", 128'(done_load), 128'(1));
        check_eq("enter_busy", 128'(busy), 128'(len > 0));
        if (len == 0) begin
            check_state("enter_empty");
            return;
        end
        idx = 0;
        stalls = 0;
        cyc = 0;
        while (idx < len && cyc < 100) begin
            @(negedge clk);
            cyc++;
            char_valid = 1'b0;
            if (cyc > 1) begin
                check_eq("stream_no_done", 128'(done_load), 128'(0));
                check_eq("stream_busy", 128'(busy), 128'(1));
                check_state("stream_hold");
            end
            if (out_valid) begin
                check_eq("out_char", 128'(out_char), 128'(line[idx]));
                check_eq("out_last", 128'(out_last), 128'(idx == len - 1));
            end
            if (out_valid && idx == 0 && stalls < nstall) begin
                rdy = 1'b0;
                stalls++;
            end else begin
                rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            out_ready = rdy;
            if (poke && cyc == 2) begin
                load       = 1'b1;
                char_valid = 1'b1;
                char_code  = 8'h5A;
            end
            if (out_valid && rdy) idx++;
        end
        if (idx < len) check_eq("stream_timeout", 128'(idx), 128'(len));
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        char_valid = 1'b0;
        model_clear();
        check_eq("post_busy", 128'(busy), 128'(0));
        check_eq("post_valid", 128'(out_valid), 128'(0));
        check_eq("post_last", 128'(out_last), 128'(0));
        check_state("post_stream");
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_letters"}, 128'(letters), 128'({DEPTH{FILL}}));
        check_eq({tag, "_cursor"}, 128'(cursor), 128'(0));
        check_eq({tag, "_length"}, 128'(length), 128'(0));
        check_eq({tag, "_done"}, 128'(done_load), 128'(0));
        check_eq({tag, "_enter"}, 128'(enter_pressed), 128'(0));
        check_eq({tag, "_busy"}, 128'(busy), 128'(0));
        check_eq({tag, "_valid"}, 128'(out_valid), 128'(0));
        check_eq({tag, "_last"}, 128'(out_last), 128'(0));
    endtask

    initial begin
        int r;
        int w;
        logic [7:0] c;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Type ABC, cursor travel limits, stream with stall and an ignored strobe
        press(8'h41, 1'b1, 1'b1);
        press(8'h42, 1'b1, 1'b1);
        press(8'h43, 1'b1, 1'b1);
        check_eq("abc_slots", 128'(letters[23:0]), 128'(24'h434241));
        check_eq("abc_cursor", 128'(cursor), 128'(3));
        check_eq("abc_length", 128'(length), 128'(3));
        repeat (4) press(K_LEFT, 1'b1, 1'b1);
        check_eq("left_stop", 128'(cursor), 128'(0));
        repeat (5) press(K_RIGHT, 1'b1, 1'b1);
        check_eq("right_stop", 128'(cursor), 128'(3));
        press(8'h44, 1'b0, 1'b1);
        press(8'h44, 1'b1, 1'b0);
        do_enter(3, 1'b0, 1'b1);

        // Backspace at the tail and at cursor 0
        press(8'h41, 1'b1, 1'b1);
        press(8'h42, 1'b1, 1'b1);
        press(8'h43, 1'b1, 1'b1);
        press(K_BS, 1'b1, 1'b1);
        check_eq("bs_slot2", 128'(letters[23:16]), 128'(8'h20));
        check_eq("bs_cursor", 128'(cursor), 128'(2));
        check_eq("bs_length", 128'(length), 128'(2));
        repeat (2) press(K_LEFT, 1'b1, 1'b1);
        press(K_BS, 1'b1, 1'b1);
        check_eq("bs0_cursor", 128'(cursor), 128'(0));
        check_eq("bs0_length", 128'(length), 128'(2));
        do_enter(0, 1'b1, 1'b0);

        // Overflow: twelve characters into ten slots
        for (int i = 0; i < 10; i++) press(8'(8'h30 + i), 1'b1, 1'b1);
        press(8'h58, 1'b1, 1'b1);
        press(8'h59, 1'b1, 1'b1);
        check_eq("ovf_slot9", 128'(letters[79:72]), 128'(8'h59));
        check_eq("ovf_cursor", 128'(cursor), 128'(9));
        check_eq("ovf_length", 128'(length), 128'(10));
        do_enter(1, 1'b1, 1'b0);

        // Empty ENTER stays in edit mode
        do_enter(0, 1'b0, 1'b0);

`ifdef TEXT_ENTRY_INSERT_EN
        press(8'h41, 1'b1, 1'b1);
        press(8'h43, 1'b1, 1'b1);
        press(K_LEFT, 1'b1, 1'b1);
        press(8'h42, 1'b1, 1'b1);
        check_eq("ins_slots", 128'(letters[23:0]), 128'(24'h434241));
        check_eq("ins_length", 128'(length), 128'(3));
        check_eq("ins_cursor", 128'(cursor), 128'(2));
        press(K_BS, 1'b1, 1'b1);
        check_eq("insbs_slots", 128'(letters[23:0]), 128'(24'h204341));
        check_eq("insbs_length", 128'(length), 128'(2));
        check_eq("insbs_cursor", 128'(cursor), 128'(1));
        do_enter(0, 1'b0, 1'b0);
`endif

        // Randomized key traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 6) begin
                do_enter($urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)));
            end else begin
                w = $urandom_range(0, 99);
                if (w < 20)      c = K_LEFT;
                else if (w < 35) c = K_RIGHT;
                else if (w < 50) c = K_BS;
                else             c = 8'($urandom_range(8'h21, 8'h7E));
                press(c, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) != 0));
            end
        end

        // Reset while streaming
        press(8'h51, 1'b1, 1'b1);
        @(negedge clk);
        load       = 1'b1;
        char_valid = 1'b1;
        char_code  = K_ENTER;
        out_ready  = 1'b0;
        @(negedge clk);
        char_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        check_eq("mid_stream_valid", 128'(out_valid), 128'(1));
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_clear();
        @(negedge clk);
        resetn = 1'b1;
        press(8'h41, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
